// File: rtl/btn_conditioner.sv
// Per-channel synchroniser, debouncer, press/release pulse and DAS/ARR auto-repeat
// for slow asynchronous level inputs. All outputs are registered.
module btn_conditioner #(
  parameter int unsigned CHANNELS        = 5,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_EN       = 1,
  parameter int unsigned DAS_CYCLES      = 17_000_000,
  parameter int unsigned ARR_CYCLES      = 5_000_000
) (
  input  logic                CLK100MHZ,
  input  logic                rst,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] released,
  output logic [CHANNELS-1:0] rpt,
  output logic                any_pressed
);

  localparam int unsigned RPT_MAX = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
  localparam int unsigned CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DAS_LAST = RPT_W'(DAS_CYCLES - 1);
  localparam logic [RPT_W-1:0] ARR_LAST = RPT_W'(ARR_CYCLES - 1);
  localparam logic             RPT_ON   = (REPEAT_EN != 0);

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_DELAY  = 2'd1,
    R_REPEAT = 2'd2
  } rstate_e;

  logic [CHANNELS-1:0] level_next;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [RPT_W-1:0]       rcnt_q, rcnt_d;
    rstate_e                state_q, state_d;
    logic                   lvl_q, lvl_d;
    logic                   press_q, press_d;
    logic                   rel_q, rel_d;
    logic                   rpt_q, rpt_d;

    assign s = sync_q[SYNC_STAGES-1];

    // State register for synchroniser, debouncer, repeat FSM and output pulses
    always_ff @(posedge CLK100MHZ) begin
      if (rst) begin
        sync_q  <= '0;
        cnt_q   <= '0;
        rcnt_q  <= '0;
        state_q <= R_IDLE;
        lvl_q   <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        rpt_q   <= 1'b0;
      end else begin
        sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_in[i]};
        cnt_q   <= cnt_d;
        rcnt_q  <= rcnt_d;
        state_q <= state_d;
        lvl_q   <= lvl_d;
        press_q <= press_d;
        rel_q   <= rel_d;
        rpt_q   <= rpt_d;
      end
    end

    // Debounce qualification followed by the repeat FSM, which keys off this cycle's edges
    always_comb begin
      cnt_d   = cnt_q;
      rcnt_d  = rcnt_q;
      state_d = state_q;
      lvl_d   = lvl_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      rpt_d   = 1'b0;

      if (s == lvl_q) begin
        cnt_d = '0;
      end else if (cnt_q == DB_LAST) begin
        cnt_d   = '0;
        lvl_d   = s;
        press_d = s;
        rel_d   = ~s;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end

      unique case (state_q)
        R_IDLE: begin
          if (press_d) begin
            rpt_d   = 1'b1;
            rcnt_d  = '0;
            state_d = RPT_ON ? R_DELAY : R_IDLE;
          end
        end
        R_DELAY: begin
          if (rel_d) begin
            rcnt_d  = '0;
            state_d = R_IDLE;
          end else if (rcnt_q == DAS_LAST) begin
            rpt_d   = 1'b1;
            rcnt_d  = '0;
            state_d = R_REPEAT;
          end else begin
            rcnt_d = rcnt_q + RPT_W'(1);
          end
        end
        R_REPEAT: begin
          if (rel_d) begin
            rcnt_d  = '0;
            state_d = R_IDLE;
          end else if (rcnt_q == ARR_LAST) begin
            rpt_d  = 1'b1;
            rcnt_d = '0;
          end else begin
            rcnt_d = rcnt_q + RPT_W'(1);
          end
        end
        default: begin
          rcnt_d  = '0;
          state_d = R_IDLE;
        end
      endcase
    end

    assign level[i]      = lvl_q;
    assign press[i]      = press_q;
    assign released[i]   = rel_q;
    assign rpt[i]        = rpt_q;
    assign level_next[i] = lvl_d;
  end

  // Registered OR of next-cycle levels so it lines up with level
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      any_pressed <= 1'b0;
    end else begin
      any_pressed <= |level_next;
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: debounce latency, glitch/bounce rejection,
// auto-repeat schedule, release priority, simultaneous channels and reset recovery.
module tb_btn_conditioner;

  localparam int unsigned CH  = 5;
  localparam int unsigned DB  = 8;
  localparam int unsigned DAS = 20;
  localparam int unsigned ARR = 5;

  logic          CLK100MHZ = 1'b0;
  logic          rst;
  logic [CH-1:0] btn_in;
  logic [CH-1:0] level, press, released, rpt;
  logic          any_pressed;
  logic [CH-1:0] nr_level, nr_press, nr_released, nr_rpt;
  logic          nr_any_pressed;

  int checks   = 0;
  int failures = 0;

  always #5 CLK100MHZ = ~CLK100MHZ;

  btn_conditioner #(
    .CHANNELS(CH), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(DB),
    .REPEAT_EN(1), .DAS_CYCLES(DAS), .ARR_CYCLES(ARR)
  ) dut (
    .CLK100MHZ(CLK100MHZ), .rst(rst), .btn_in(btn_in),
    .level(level), .press(press), .released(released), .rpt(rpt),
    .any_pressed(any_pressed)
  );

  btn_conditioner #(
    .CHANNELS(CH), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(DB),
    .REPEAT_EN(0), .DAS_CYCLES(DAS), .ARR_CYCLES(ARR)
  ) dut_nr (
    .CLK100MHZ(CLK100MHZ), .rst(rst), .btn_in(btn_in),
    .level(nr_level), .press(nr_press), .released(nr_released), .rpt(nr_rpt),
    .any_pressed(nr_any_pressed)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK100MHZ);
  endtask

  logic [63:0] obs_a, obs_b, obs_c, obs_d, exp_a;

  initial begin
    rst    = 1'b1;
    btn_in = '0;
    wait_cyc(3);
    rst = 1'b0;
    check("reset_level", 64'(level), 64'd0);
    check("reset_pulses", 64'({press, released, rpt, any_pressed}), 64'd0);
    check("reset_nr", 64'({nr_level, nr_press, nr_released, nr_rpt, nr_any_pressed}), 64'd0);

    // Clean press on channel 0: level/press/rpt appear after edge 10
    btn_in[0] = 1'b1;
    wait_cyc(9);
    check("clean_pre_level", 64'({level, press, rpt}), 64'd0);
    wait_cyc(1);
    check("clean_level", 64'(level), 64'b00001);
    check("clean_press", 64'(press), 64'b00001);
    check("clean_rpt", 64'(rpt), 64'b00001);
    check("clean_any", 64'(any_pressed), 64'd1);
    check("clean_nr_rpt", 64'(nr_rpt), 64'b00001);
    wait_cyc(1);
    check("clean_press_drop", 64'({press, rpt}), 64'd0);
    check("clean_level_hold", 64'(level), 64'b00001);

    // Auto-repeat: edges P+1..P+55 (P = 10), bit d-1 for offset d; edge P+1 already sampled
    obs_a = '0; obs_b = '0; obs_c = '0; exp_a = '0;
    obs_a[0] = rpt[0];
    obs_b[0] = nr_rpt[0];
    obs_c[0] = press[0];
    for (int d = 2; d <= 55; d++) begin
      wait_cyc(1);
      obs_a[d-1] = rpt[0];
      obs_b[d-1] = nr_rpt[0];
      obs_c[d-1] = press[0] | (|rpt[CH-1:1]);
    end
    for (int d = 1; d <= 55; d++)
      exp_a[d-1] = (d == int'(DAS)) || (d > int'(DAS) && ((d - int'(DAS)) % int'(ARR)) == 0);
    check("rpt_schedule", obs_a, exp_a);
    check("rpt_nr_none", obs_b, 64'd0);
    check("rpt_no_extra_press", obs_c, 64'd0);

    // Drop pin before edge 66: rpt at 70, release at 75 wins over repeat expiring at 75
    btn_in[0] = 1'b0;
    obs_a = '0; obs_b = '0; obs_c = '0; obs_d = '0;
    for (int j = 0; j < 15; j++) begin
      wait_cyc(1);
      obs_a[j] = rpt[0];
      obs_b[j] = released[0];
      obs_c[j] = level[0];
      obs_d[j] = nr_released[0] | nr_rpt[0];
    end
    check("rel_rpt", obs_a, 64'h10);
    check("rel_pulse", obs_b, 64'h200);
    check("rel_level", obs_c, 64'h1ff);
    check("rel_nr", obs_d, 64'h200);
    check("rel_any", 64'(any_pressed), 64'd0);

    // Glitch: 7 high cycles on channel 2 must be ignored
    btn_in[2] = 1'b1;
    wait_cyc(7);
    btn_in[2] = 1'b0;
    obs_a = '0;
    for (int j = 0; j < 40; j++) begin
      wait_cyc(1);
      obs_a[j] = (|level) | (|press) | (|released) | (|rpt) | any_pressed;
    end
    check("glitch_quiet", obs_a, 64'd0);

    // Bounce on channel 1: toggles every 3 cycles, final rise at toggle 10
    obs_a = '0;
    for (int k = 0; k <= 10; k++) begin
      btn_in[1] = ((k % 2) == 0);
      if (k < 10) begin
        for (int j = 0; j < 3; j++) begin
          wait_cyc(1);
          obs_a[k*3+j] = press[1] | released[1];
        end
      end
    end
    for (int j = 0; j < 15; j++) begin
      wait_cyc(1);
      obs_a[30+j] = press[1] | released[1];
    end
    check("bounce_single_press", obs_a, 64'd1 << 39);
    check("bounce_level", 64'(level), 64'b00010);
    btn_in[1] = 1'b0;
    wait_cyc(15);
    check("bounce_released", 64'(level), 64'd0);

    // Simultaneous rise on channels 1 and 3
    btn_in[1] = 1'b1;
    btn_in[3] = 1'b1;
    obs_a = '0; obs_b = '0;
    for (int j = 0; j < 12; j++) begin
      wait_cyc(1);
      if (j == 9) check("simul_press_vec", 64'(press), 64'b01010);
      obs_a[j] = press[1];
      obs_b[j] = press[3];
    end
    check("simul_ch1", obs_a, 64'd1 << 9);
    check("simul_ch3", obs_b, 64'd1 << 9);
    btn_in[1] = 1'b0;
    btn_in[3] = 1'b0;
    wait_cyc(15);
    check("simul_idle", 64'(level), 64'd0);

    // Reset while channel 0 is in R_REPEAT with the pin held
    btn_in[0] = 1'b1;
    wait_cyc(10);
    check("rst_pre_press", 64'(press), 64'b00001);
    wait_cyc(23);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    check("rst_outputs", 64'({level, press, released, rpt, any_pressed}), 64'd0);
    check("rst_nr_outputs", 64'({nr_level, nr_press, nr_released, nr_rpt, nr_any_pressed}), 64'd0);
    obs_a = '0; obs_b = '0; obs_c = '0; obs_d = '0;
    for (int j = 0; j < 33; j++) begin
      wait_cyc(1);
      obs_a[j] = press[0];
      obs_b[j] = rpt[0];
      obs_c[j] = released[0] | nr_released[0];
      obs_d[j] = nr_rpt[0];
    end
    check("rst_fresh_press", obs_a, 64'd1 << 9);
    check("rst_fresh_rpt", obs_b, (64'd1 << 9) | (64'd1 << 29));
    check("rst_no_release", obs_c, 64'd0);
    check("rst_nr_rpt", obs_d, 64'd1 << 9);
    btn_in[0] = 1'b0;
    wait_cyc(15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Parametrised N-channel input conditioner for the board pushbuttons and other slow asynchronous level inputs. It runs on CLK100MHZ and, per channel, provides:

- a multi-stage synchroniser;
- a glitch-rejecting debouncer;
- registered press and release pulses;
- an optional DAS/ARR auto-repeat pulse stream.

It replaces the fixed two-channel button debouncers and feeds the game-side input logic, which takes one instance covering every button.

## Interface

Parameters:
- CHANNELS, 5, number of independent input channels (≥1)
- SYNC_STAGES, 2, synchroniser flops per channel (≥2)
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable samples needed to change level (10 ms; ≥1)
- REPEAT_EN, 1, 1 = auto-repeat enabled; 0 = rpt mirrors press
- DAS_CYCLES, 17_000_000, delay from press pulse to first repeat pulse (170 ms; ≥1)
- ARR_CYCLES, 5_000_000, period between subsequent repeat pulses (50 ms; ≥1)

Ports:
- CLK100MHZ  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- btn_in  in  CHANNELS  raw asynchronous inputs, active-high
- level  out  CHANNELS  debounced held state
- press  out  CHANNELS  one-cycle pulse on debounced rising edge
- release  out  CHANNELS  one-cycle pulse on debounced falling edge
- rpt  out  CHANNELS  one-cycle pulse at press, then auto-repeat while held
- any_pressed  out  1  OR of level, registered

## Operation

Channels are fully independent. There is no arbitration, and any number of channels may pulse in the same cycle.

Synchroniser:
- s = output of a SYNC_STAGES-deep flop chain on btn_in[i].

Debouncer (counter cnt, width $clog2(DEBOUNCE_CYCLES)):
- If s == level: cnt ← 0.
- Else if cnt == DEBOUNCE_CYCLES-1: level ← s, cnt ← 0, and press or release pulses that cycle.
- Else: cnt ← cnt+1.
- Any sample equal to level aborts the pending change and resets cnt.

Repeat FSM, states R_IDLE, R_DELAY, R_REPEAT (counter rcnt, width $clog2(max(DAS_CYCLES,ARR_CYCLES))):
- R_IDLE:
  - On press: rpt pulses (same cycle as press), rcnt ← 0, go to R_DELAY if REPEAT_EN else stay in R_IDLE.
- R_DELAY:
  - If rcnt == DAS_CYCLES-1: rpt pulses, rcnt ← 0, go to R_REPEAT.
  - Else: rcnt++.
- R_REPEAT:
  - If rcnt == ARR_CYCLES-1: rpt pulses, rcnt ← 0.
  - Else: rcnt++.
- Any state: level falling (release cycle) → R_IDLE with no rpt pulse. Release takes priority over a repeat expiring in the same cycle.

any_pressed ← |level_next. It is registered and aligned with level.

Reset:
- All outputs go to 0; sync flops, cnt and rcnt go to 0; FSM goes to R_IDLE.
- Reset mid-operation discards pending debounce and repeat progress. No release pulse is emitted.
- An input still held high after reset is re-qualified from scratch and produces a fresh press.

## Timing

- All outputs are registered. There is no combinational path from btn_in.
- Latency: counting the first edge that samples a new pin value as edge 1, level and press change at edge SYNC_STAGES+DEBOUNCE_CYCLES. The same rule applies to release.
- A pulse train shorter than DEBOUNCE_CYCLES samples in s produces no output.
- Repeat pulses occur at the press cycle P, then P+DAS_CYCLES, then every ARR_CYCLES after that while level stays high.
- press, release and rpt are exactly one cycle wide.
- press and release never coincide on one channel.
- Critical path: one counter compare per channel. It must close at 100 MHz.

## Test plan

Bench parameters: CHANNELS=5, SYNC_STAGES=2, DEBOUNCE_CYCLES=8, DAS_CYCLES=20, ARR_CYCLES=5.

- Clean press: btn_in[0] rises before edge 1 → level[0], press[0], rpt[0] and any_pressed asserted after edge 10. press and rpt drop after edge 11. The other channels stay 0.
- Glitch: btn_in[2] high for 7 cycles, then low → no change on level, press, release or rpt for 40 cycles.
- Bounce: btn_in[1] toggles every 3 cycles for 30 cycles, then stays high → exactly one press[1]. It occurs 10 edges after the last toggle.
- Auto-repeat: hold btn_in[0] for 60 cycles after press at P → rpt at P, P+20, P+25, P+30, …. Release → one release pulse and no further rpt, even when a repeat would have expired that cycle.
- REPEAT_EN=0 build, same hold → rpt pulses only at P.
- Simultaneous: btn_in[1] and btn_in[3] rise together → press[1] and press[3] pulse on the same edge.
- Reset mid-repeat: rst for 1 cycle while channel 0 is in R_REPEAT with the pin held → all outputs 0 after the rst edge, and no release pulse. A new press arrives 10 edges after rst deasserts, then a repeat 20 cycles later.
